vga_sync_gen: RTL and testbench
===============================

Name: vga_sync_gen

Overview:
- Generates VGA raster timing: hsync, vsync, blank and the pixel position (pos_h, pos_v) consumed by the pixel/colour generators.
- Default timing is 640x480 @ 60 Hz, with a 25 MHz pixel rate derived from the system clock by an integer clock-enable divider.
- All outputs are registered, so consumers sample them directly on clk.

Parameters:
- CLK_DIV, 2, system clocks per pixel; legal range is 1 or more.
- H_VISIBLE, 640, active pixels per line.
- H_FRONT, 16, horizontal front porch in pixels.
- H_SYNC, 96, hsync width in pixels.
- H_BACK, 48, horizontal back porch in pixels.
- V_VISIBLE, 480, active lines per frame.
- V_FRONT, 10, vertical front porch in lines.
- V_SYNC, 2, vsync width in lines.
- V_BACK, 33, vertical back porch in lines.
- SYNC_POL, 0, sync active level; 0 means active-low.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- pos_h  output  10  horizontal pixel counter, 0..H_TOTAL-1.
- pos_v  output  10  vertical line counter, 0..V_TOTAL-1.
- blank  output  1  high outside the visible region.
- hsync  output  1  horizontal sync at SYNC_POL level when active.
- vsync  output  1  vertical sync at SYNC_POL level when active.
- pix_tick  output  1  one-clk pulse marking each pixel period.
- line_start  output  1  one-clk pulse when pos_h becomes 0.
- frame_start  output  1  one-clk pulse when (pos_h,pos_v) becomes (0,0).

Behaviour:
- Derived totals: H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL = V_VISIBLE+V_FRONT+V_SYNC+V_BACK (525). Both must be 1024 or less.
- Divider div_cnt counts 0..CLK_DIV-1, then wraps.
  - tick = (div_cnt == CLK_DIV-1).
  - pix_tick is registered, high for exactly the one clk after each tick edge.
  - With CLK_DIV=1, pix_tick is constantly 1 after reset.
- Internal counters h,v reset to 0. On each tick edge:
  - Outputs load the decode of the current (h,v).
  - h increments, wrapping H_TOTAL-1 to 0.
  - On that wrap only, v increments, wrapping V_TOTAL-1 to 0.
- Decode for position (h,v):
  - blank = (h >= H_VISIBLE) or (v >= V_VISIBLE).
  - hsync is active when H_VISIBLE+H_FRONT <= h < H_VISIBLE+H_FRONT+H_SYNC (656..751).
  - vsync is active when V_VISIBLE+V_FRONT <= v < V_VISIBLE+V_FRONT+V_SYNC (490..491).
  - pos_h = h, pos_v = v.
  - pos_v ranges 0..479 in the visible region; row 0 is the top line.
- Latency: outputs change only on tick edges and hold for CLK_DIV clocks. hsync, vsync, blank and pos are mutually aligned, with zero skew between them.
- line_start and frame_start:
  - Set on the tick edge that loads h=0 (line_start) or h=0,v=0 (frame_start).
  - Cleared on the next clk edge, so they are exactly 1 clk wide regardless of CLK_DIV.
  - Each coincides with that clk's pix_tick.
- Reset values, held while rst=1: pos_h=0, pos_v=0, blank=1, hsync=vsync=~SYNC_POL (inactive), pix_tick=0, line_start=0, frame_start=0, div_cnt=0, h=v=0.
- After reset release, the first tick edge occurs CLK_DIV clocks after the first clk edge with rst=0. That edge loads (0,0), blank=0, line_start=1, frame_start=1.
- Reset mid-frame or mid-divider: everything returns to the reset values on the next clk edge. There is no partial-line completion. The restart sequence is identical to the one after power-up.
- No other inputs; the sequence is free-running and fully deterministic.

Test Plan:
- Reset/start, CLK_DIV=2:
  - While rst=1: pos=(0,0), blank=1, hsync=vsync=1, all pulses 0.
  - 2 clocks after release: pos=(0,0), blank=0, frame_start=1 for 1 clk.
- Line timing:
  - blank rises when pos_h=640, i.e. 1280 clocks after line start.
  - hsync is low for 192 clocks, from pos_h=656 to pos_h=751.
  - line_start period is 1600 clocks; pos_h wraps 799 to 0 and pos_v increments.
- Frame timing:
  - blank stays high for all of pos_v=480..524.
  - vsync is low for exactly 2 lines (3200 clocks), from pos_v=490.
  - frame_start period is 840000 clocks; pos_v wraps 524 to 0.
- Reset mid-frame: assert rst for 1 clk at pos=(300,200) -> next edge gives reset values; restart matches the start scenario exactly.
- CLK_DIV=1, SYNC_POL=1:
  - pix_tick is constantly high; line period is 800 clocks.
  - hsync is high only for pos_h 656..751; idle level is low.
  - frame period is 420000 clocks.

Source files
------------

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: free-running h/v counters advanced by a clock-enable
// divider, with registered position, blank, sync and start-of-line/frame pulses.
module vga_sync_gen #(
   parameter int unsigned CLK_DIV   = 2,
   parameter int unsigned H_VISIBLE = 640,
   parameter int unsigned H_FRONT   = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BACK    = 48,
   parameter int unsigned V_VISIBLE = 480,
   parameter int unsigned V_FRONT   = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BACK    = 33,
   parameter int unsigned SYNC_POL  = 0
) (
   input  logic       clk,
   input  logic       rst,
   output logic [9:0] pos_h,
   output logic [9:0] pos_v,
   output logic       blank,
   output logic       hsync,
   output logic       vsync,
   output logic       pix_tick,
   output logic       line_start,
   output logic       frame_start
);

   localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [9:0]  H_LAST      = 10'(H_TOTAL - 1);
   localparam logic [9:0]  V_LAST      = 10'(V_TOTAL - 1);
   localparam logic [10:0] H_VIS       = 11'(H_VISIBLE);
   localparam logic [10:0] H_SYNC_BEG  = 11'(H_VISIBLE + H_FRONT);
   localparam logic [10:0] H_SYNC_END  = 11'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [10:0] V_VIS       = 11'(V_VISIBLE);
   localparam logic [10:0] V_SYNC_BEG  = 11'(V_VISIBLE + V_FRONT);
   localparam logic [10:0] V_SYNC_END  = 11'(V_VISIBLE + V_FRONT + V_SYNC);
   localparam logic        SYNC_ACT    = (SYNC_POL != 0);

   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic [9:0]       h_q, h_d;
   logic [9:0]       v_q, v_d;
   logic [9:0]       pos_h_q, pos_h_d;
   logic [9:0]       pos_v_q, pos_v_d;
   logic             blank_q, blank_d;
   logic             hsync_q, hsync_d;
   logic             vsync_q, vsync_d;
   logic             pix_tick_q, pix_tick_d;
   logic             line_start_q, line_start_d;
   logic             frame_start_q, frame_start_d;

   logic tick;
   logic h_last;
   logic v_last;
   logic in_hsync;
   logic in_vsync;

   always_comb begin
      tick     = (div_cnt_q == DIV_LAST);
      h_last   = (h_q == H_LAST);
      v_last   = (v_q == V_LAST);
      in_hsync = ({1'b0, h_q} >= H_SYNC_BEG) && ({1'b0, h_q} < H_SYNC_END);
      in_vsync = ({1'b0, v_q} >= V_SYNC_BEG) && ({1'b0, v_q} < V_SYNC_END);

      div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
      h_d       = h_q;
      v_d       = v_q;
      if (tick) begin
         h_d = h_last ? '0 : h_q + 10'd1;
         if (h_last) begin
            v_d = v_last ? '0 : v_q + 10'd1;
         end
      end
   end

   // Outputs capture the decode of the position the counters hold at the tick,
   // so every output moves on the same edge; pulses drop on the following clk.
   always_comb begin
      pos_h_d       = pos_h_q;
      pos_v_d       = pos_v_q;
      blank_d       = blank_q;
      hsync_d       = hsync_q;
      vsync_d       = vsync_q;
      pix_tick_d    = tick;
      line_start_d  = tick && (h_q == '0);
      frame_start_d = tick && (h_q == '0) && (v_q == '0);
      if (tick) begin
         pos_h_d = h_q;
         pos_v_d = v_q;
         blank_d = ({1'b0, h_q} >= H_VIS) || ({1'b0, v_q} >= V_VIS);
         hsync_d = in_hsync ? SYNC_ACT : ~SYNC_ACT;
         vsync_d = in_vsync ? SYNC_ACT : ~SYNC_ACT;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt_q     <= '0;
         h_q           <= '0;
         v_q           <= '0;
         pos_h_q       <= '0;
         pos_v_q       <= '0;
         blank_q       <= 1'b1;
         hsync_q       <= ~SYNC_ACT;
         vsync_q       <= ~SYNC_ACT;
         pix_tick_q    <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         div_cnt_q     <= div_cnt_d;
         h_q           <= h_d;
         v_q           <= v_d;
         pos_h_q       <= pos_h_d;
         pos_v_q       <= pos_v_d;
         blank_q       <= blank_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         pix_tick_q    <= pix_tick_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign pos_h       = pos_h_q;
   assign pos_v       = pos_v_q;
   assign blank       = blank_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign pix_tick    = pix_tick_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: three instances (default 640x480, small CLK_DIV=2 active-low,
// small CLK_DIV=1 active-high) checked every cycle against an arithmetic raster model.
module tb_vga_sync_gen;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [9:0] a_ph, a_pv, b_ph, b_pv, c_ph, c_pv;
   logic a_bl, a_hs, a_vs, a_pt, a_ls, a_fs;
   logic b_bl, b_hs, b_vs, b_pt, b_ls, b_fs;
   logic c_bl, c_hs, c_vs, c_pt, c_ls, c_fs;

   vga_sync_gen #(.CLK_DIV(2), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
                  .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .SYNC_POL(0)) u_a (
      .clk(clk), .rst(rst), .pos_h(a_ph), .pos_v(a_pv), .blank(a_bl), .hsync(a_hs),
      .vsync(a_vs), .pix_tick(a_pt), .line_start(a_ls), .frame_start(a_fs));

   vga_sync_gen #(.CLK_DIV(1), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
                  .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .SYNC_POL(1)) u_b (
      .clk(clk), .rst(rst), .pos_h(b_ph), .pos_v(b_pv), .blank(b_bl), .hsync(b_hs),
      .vsync(b_vs), .pix_tick(b_pt), .line_start(b_ls), .frame_start(b_fs));

   vga_sync_gen u_c (
      .clk(clk), .rst(rst), .pos_h(c_ph), .pos_v(c_pv), .blank(c_bl), .hsync(c_hs),
      .vsync(c_vs), .pix_tick(c_pt), .line_start(c_ls), .frame_start(c_fs));

   logic [25:0] pack_a, pack_b, pack_c;
   assign pack_a = {a_ph, a_pv, a_bl, a_hs, a_vs, a_pt, a_ls, a_fs};
   assign pack_b = {b_ph, b_pv, b_bl, b_hs, b_vs, b_pt, b_ls, b_fs};
   assign pack_c = {c_ph, c_pv, c_bl, c_hs, c_vs, c_pt, c_ls, c_fs};

   int unsigned total = 0;
   int unsigned bad   = 0;
   int unsigned n_edges = 0;
   bit          live = 1'b0;
   longint      cyc = 0;

   task automatic check(input string name, input longint act, input longint exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // After n clk edges out of reset, n/div pixel periods have elapsed; the outputs
   // show the raster position of the last one, i.e. pixel index n/div - 1.
   function automatic logic [25:0] model(input int unsigned n, input int unsigned div,
         input int unsigned hv, input int unsigned hf, input int unsigned hs, input int unsigned hb,
         input int unsigned vv, input int unsigned vf, input int unsigned vs, input int unsigned vb,
         input logic pol);
      int unsigned ht, vt, k, p, h, v;
      logic bl, hy, vy, pt, ls, fs;
      ht = hv + hf + hs + hb;
      vt = vv + vf + vs + vb;
      k  = n / div;
      if (k == 0) return {10'd0, 10'd0, 1'b1, ~pol, ~pol, 3'b000};
      p  = k - 1;
      h  = p % ht;
      v  = (p / ht) % vt;
      bl = (h >= hv) || (v >= vv);
      hy = (h >= hv + hf && h < hv + hf + hs) ? pol : ~pol;
      vy = (v >= vv + vf && v < vv + vf + vs) ? pol : ~pol;
      pt = (n % div) == 0;
      ls = pt && h == 0;
      fs = ls && v == 0;
      return {10'(h), 10'(v), bl, hy, vy, pt, ls, fs};
   endfunction

   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         n_edges = 0;
         live    = 1'b1;
      end else begin
         n_edges++;
      end
   end

   always @(negedge clk) begin
      if (live) begin
         check("model_a", pack_a, model(n_edges, 2, 8, 2, 3, 2, 6, 2, 2, 3, 1'b0));
         check("model_b", pack_b, model(n_edges, 1, 8, 2, 3, 2, 6, 2, 2, 3, 1'b1));
         check("model_c", pack_c, model(n_edges, 2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0));
      end
   end

   localparam logic [25:0] RST_LO = {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 3'b000};
   localparam logic [25:0] RST_HI = {10'd0, 10'd0, 1'b1, 1'b0, 1'b0, 3'b000};

   task automatic check_start();
      check("rst_a", pack_a, RST_LO);
      check("rst_b", pack_b, RST_HI);
      check("rst_c", pack_c, RST_LO);
      rst = 1'b0;
      @(negedge clk);
      check("start_a_e1", pack_a, RST_LO);
      check("start_b_e1", pack_b, {20'd0, 1'b0, 1'b0, 1'b0, 3'b111});
      @(negedge clk);
      check("start_a_e2", pack_a, {20'd0, 1'b0, 1'b1, 1'b1, 3'b111});
      check("start_c_e2", pack_c, {20'd0, 1'b0, 1'b1, 1'b1, 3'b111});
      check("start_b_e2", pack_b, {10'd1, 10'd0, 1'b0, 1'b0, 1'b0, 3'b100});
      @(negedge clk);
      check("start_a_e3", pack_a, {20'd0, 1'b0, 1'b1, 1'b1, 3'b000});
      check("start_c_e3", pack_c, {20'd0, 1'b0, 1'b1, 1'b1, 3'b000});
   endtask

   task automatic measure(input int unsigned n_cyc);
      longint c_ls_t = -1, a_fs_t = -1, b_fs_t = -1, b_ls_t = -1;
      int     c_hs_run = -1, a_vs_run = -1, b_hs_run = -1;
      logic   c_bl_p = c_bl, c_hs_p = c_hs, a_vs_p = a_vs, b_hs_p = b_hs;
      for (int i = 0; i < int'(n_cyc); i++) begin
         @(negedge clk);
         if (c_ls) begin
            if (c_ls_t >= 0) check("c_line_period", cyc - c_ls_t, 1600);
            c_ls_t = cyc;
         end
         if (c_bl && !c_bl_p && c_ls_t >= 0) check("c_blank_rise", cyc - c_ls_t, 1280);
         if (!c_hs && c_hs_p) c_hs_run = 0;
         if (!c_hs && c_hs_run >= 0) c_hs_run++;
         if (c_hs && !c_hs_p && c_hs_run >= 0) check("c_hsync_len", c_hs_run, 192);
         if (a_fs) begin
            if (a_fs_t >= 0) check("a_frame_period", cyc - a_fs_t, 390);
            a_fs_t = cyc;
         end
         if (!a_vs && a_vs_p) a_vs_run = 0;
         if (!a_vs && a_vs_run >= 0) a_vs_run++;
         if (a_vs && !a_vs_p && a_vs_run >= 0) check("a_vsync_len", a_vs_run, 60);
         check("b_pix_tick", b_pt, 1);
         if (b_ls) begin
            if (b_ls_t >= 0) check("b_line_period", cyc - b_ls_t, 15);
            b_ls_t = cyc;
         end
         if (b_fs) begin
            if (b_fs_t >= 0) check("b_frame_period", cyc - b_fs_t, 195);
            b_fs_t = cyc;
         end
         if (b_hs && !b_hs_p) b_hs_run = 0;
         if (b_hs && b_hs_run >= 0) b_hs_run++;
         if (!b_hs && b_hs_p && b_hs_run >= 0) check("b_hsync_len", b_hs_run, 3);
         c_bl_p = c_bl;
         c_hs_p = c_hs;
         a_vs_p = a_vs;
         b_hs_p = b_hs;
      end
   endtask

   initial begin
      bit found = 1'b0;
      // Hand-computed points that pin the model to the default 640x480 timing.
      check("pin_h640", model(1282, 2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0),
            {10'd640, 10'd0, 1'b1, 1'b1, 1'b1, 3'b100});
      check("pin_h656", model(1314, 2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0),
            {10'd656, 10'd0, 1'b1, 1'b0, 1'b1, 3'b100});
      check("pin_wrap", model(1602, 2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0),
            {10'd0, 10'd1, 1'b0, 1'b1, 1'b1, 3'b110});
      check("pin_v490", model(784002, 2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0),
            {10'd0, 10'd490, 1'b1, 1'b1, 1'b0, 3'b110});
      check("pin_frame", model(840002, 2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0),
            {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 3'b111});
      check("pin_b_h10", model(11, 1, 8, 2, 3, 2, 6, 2, 2, 3, 1'b1),
            {10'd10, 10'd0, 1'b1, 1'b1, 1'b0, 3'b100});

      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_start();
      measure(3400);

      for (int i = 0; i < 500 && !found; i++) begin
         @(negedge clk);
         if (a_ph == 10'd4 && a_pv == 10'd3 && !a_pt) found = 1'b1;
      end
      check("mid_pos_found", found, 1);
      rst = 1'b1;
      @(negedge clk);
      check_start();
      measure(1000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
